// File: rtl/pulp_boot_seq.sv
// Boot/reset sequencer for PULPino: selects run/fetch requests from debounced board switches
// or the PS control word, then sequences SoC reset release and fetch enable after clock lock.
module pulp_boot_seq #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned RST_HOLD   = 16,
    parameter int unsigned FETCH_DLY  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_run_i,
    input  logic        sw_fetch_i,
    input  logic [31:0] ps_ctrl_i,
    input  logic        clk_locked_i,
    output logic        rstn_pulpino_o,
    output logic        fetch_en_o,
    output logic [1:0]  state_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DLY - 1);

    // Index 0 = run switch, index 1 = fetch switch
    logic [1:0]       sw_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       db_q, db_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rstn_q, rstn_d;
    logic             fetch_q, fetch_d;

    logic             run_req, fetch_req, abort;
    logic             unused_ps;

    assign sw_raw    = {sw_fetch_i, sw_run_i};
    assign unused_ps = ^ps_ctrl_i[29:1];

    always_comb begin
        db_d      = db_q;
        deb_cnt_d = deb_cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                db_d[i]      = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign run_req   = ps_ctrl_i[30] ? ps_ctrl_i[31] : db_q[0];
    assign fetch_req = ps_ctrl_i[30] ? ps_ctrl_i[0]  : db_q[1];
    assign abort     = !run_req || !clk_locked_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                cnt_d = '0;
                if (!abort) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == FETCH_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (abort) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            end
        endcase
        // Outputs registered from next state so they change on the same edge as the state
        rstn_d  = (state_d == ST_WAIT) || (state_d == ST_RUN);
        fetch_d = (state_d == ST_RUN) && fetch_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            deb_cnt_q <= '{default: '0};
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            rstn_q    <= 1'b0;
            fetch_q   <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rstn_q    <= rstn_d;
            fetch_q   <= fetch_d;
        end
    end

    assign rstn_pulpino_o = rstn_q;
    assign fetch_en_o     = fetch_q;
    assign state_o        = state_q;
    assign busy_o         = (state_q != ST_RUN);

endmodule

// File: tb/tb_pulp_boot_seq.sv
// Directed self-checking bench for pulp_boot_seq with short debounce/hold/delay settings.
module tb_pulp_boot_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_run_i, sw_fetch_i;
    logic [31:0] ps_ctrl_i;
    logic        clk_locked_i;
    logic        rstn_pulpino_o, fetch_en_o, busy_o;
    logic [1:0]  state_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pulp_boot_seq #(
        .CNT_W      (16),
        .DEB_CYCLES (4),
        .RST_HOLD   (3),
        .FETCH_DLY  (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_run_i       (sw_run_i),
        .sw_fetch_i     (sw_fetch_i),
        .ps_ctrl_i      (ps_ctrl_i),
        .clk_locked_i   (clk_locked_i),
        .rstn_pulpino_o (rstn_pulpino_o),
        .fetch_en_o     (fetch_en_o),
        .state_o        (state_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected {rstn, fetch, state, busy}
    task automatic expect_out(input string tag, input logic r, input logic f, input logic [1:0] s);
        check({tag, ".rstn"},  {31'd0, rstn_pulpino_o}, {31'd0, r});
        check({tag, ".fetch"}, {31'd0, fetch_en_o},     {31'd0, f});
        check({tag, ".state"}, {30'd0, state_o},        {30'd0, s});
        check({tag, ".busy"},  {31'd0, busy_o},         {31'd0, (s != 2'd3)});
    endtask

    initial begin
        rst_n = 1'b0; sw_run_i = 1'b0; sw_fetch_i = 1'b0;
        ps_ctrl_i = 32'h0; clk_locked_i = 1'b1;
        tick(2);
        expect_out("reset", 1'b0, 1'b0, 2'd0);

        // Switch path: db at edge 6, HOLD at 7, rstn at 10, fetch at 15
        rst_n = 1'b1; sw_run_i = 1'b1; sw_fetch_i = 1'b1;
        tick(6);  expect_out("sw_deb6",   1'b0, 1'b0, 2'd0);
        tick(1);  expect_out("sw_hold",   1'b0, 1'b0, 2'd1);
        tick(2);  expect_out("sw_hold3",  1'b0, 1'b0, 2'd1);
        tick(1);  expect_out("sw_wait",   1'b1, 1'b0, 2'd2);
        tick(4);  expect_out("sw_wait5",  1'b1, 1'b0, 2'd2);
        tick(1);  expect_out("sw_run",    1'b1, 1'b1, 2'd3);

        // 1-cycle glitch is filtered
        sw_run_i = 1'b0; tick(1); sw_run_i = 1'b1;
        tick(8);  expect_out("glitch1",   1'b1, 1'b1, 2'd3);

        // 4-cycle low is accepted at edge a+5, FSM leaves RUN at a+6
        sw_run_i = 1'b0; tick(4); sw_run_i = 1'b1;
        tick(1);  expect_out("low4_a4",   1'b1, 1'b1, 2'd3);
        tick(1);  expect_out("low4_a5",   1'b1, 1'b1, 2'd3);
        tick(1);  expect_out("low4_a6",   1'b0, 1'b0, 2'd0);

        // PS source, switches held low
        rst_n = 1'b0; sw_run_i = 1'b0; sw_fetch_i = 1'b0;
        tick(2);  expect_out("reset2",    1'b0, 1'b0, 2'd0);
        rst_n = 1'b1; ps_ctrl_i = 32'hC000_0001;
        tick(1);  expect_out("ps_hold",   1'b0, 1'b0, 2'd1);
        tick(2);  expect_out("ps_hold3",  1'b0, 1'b0, 2'd1);
        tick(1);  expect_out("ps_wait",   1'b1, 1'b0, 2'd2);
        tick(4);  expect_out("ps_wait5",  1'b1, 1'b0, 2'd2);
        tick(1);  expect_out("ps_run",    1'b1, 1'b1, 2'd3);
        ps_ctrl_i = 32'hC000_0000;
        tick(1);  expect_out("ps_nofetch", 1'b1, 1'b0, 2'd3);
        ps_ctrl_i = 32'hC000_0001;
        tick(1);  expect_out("ps_refetch", 1'b1, 1'b1, 2'd3);

        // Lock drop for one cycle in RUN -> full resequence
        clk_locked_i = 1'b0;
        tick(1);  expect_out("lock_drop", 1'b0, 1'b0, 2'd0);
        clk_locked_i = 1'b1;
        tick(1);  expect_out("relock_hold", 1'b0, 1'b0, 2'd1);
        tick(2);  expect_out("relock_hold3", 1'b0, 1'b0, 2'd1);
        tick(1);  expect_out("relock_wait", 1'b1, 1'b0, 2'd2);
        tick(4);  expect_out("relock_wait5", 1'b1, 1'b0, 2'd2);
        tick(1);  expect_out("relock_run", 1'b1, 1'b1, 2'd3);

        // Lock drop at HOLD cnt=1 restarts the hold count
        ps_ctrl_i = 32'h4000_0001;
        tick(1);  expect_out("ps_abort",  1'b0, 1'b0, 2'd0);
        ps_ctrl_i = 32'hC000_0001;
        tick(2);  expect_out("hold_cnt1", 1'b0, 1'b0, 2'd1);
        clk_locked_i = 1'b0;
        tick(1);  expect_out("hold_drop", 1'b0, 1'b0, 2'd0);
        clk_locked_i = 1'b1;
        tick(1);  expect_out("hold_again", 1'b0, 1'b0, 2'd1);
        tick(2);  expect_out("hold_again3", 1'b0, 1'b0, 2'd1);
        tick(1);  expect_out("hold_release", 1'b1, 1'b0, 2'd2);

        // Synchronous reset mid-WAIT
        tick(2);
        rst_n = 1'b0;
        tick(1);  expect_out("mid_reset", 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(1);  expect_out("post_reset", 1'b0, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
